// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF->ID instruction queue: bus widths, zero word and the bubble.
package if_id_queue_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstAddrW-1:0] ZeroWord = '0;
  // addi x0,x0,0
  localparam logic [InstW-1:0]     InstNone = 32'h0000_0013;

endpackage

// File: rtl/if_id_queue.sv
// IF->ID pipeline queue: DEPTH-entry FIFO between fetch and decode, flushed by EX branches,
// presenting a NOP bubble with pc 0 whenever it is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrW,
  parameter int unsigned       INST_W   = InstW,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(InstNone)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic [INST_W-1:0]          inst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       ex_branch_flag_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [INST_W-1:0]          inst_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned EntryW = ADDR_W + INST_W;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] head;
  logic              push, pop;

  // Ready depends only on registered occupancy, so a full queue refuses a push even when
  // decode pops in the same cycle.
  assign in_ready_o  = (count_q < CntW'(DEPTH)) & ~ex_branch_flag_i;
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign head    = mem_q[rd_ptr_q];
  assign pc_o    = out_valid_o ? head[EntryW-1:INST_W] : ADDR_W'(ZeroWord);
  assign inst_o  = out_valid_o ? head[INST_W-1:0] : NOP_INST;
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ex_branch_flag_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pc_i, inst_i};
    end
  end

endmodule
